kernel_bram_loader: RTL and testbench
=====================================

Name: kernel_bram_loader

Overview:
- Writer side of the conv2d kernel BRAM: accepts a stream of 16-bit 3x3 kernel weights, packs 9 weights into one 144-bit word and writes it to BRAM port A (write port), one word per input channel.
- Sits between the weight DMA/stream source and the kernel BRAM. The conv datapath reads the same BRAM on port B.
- Signals completion so the conv controller can start port B reads.

Parameters:
- KERNEL_WIDTH, 16, bit width of one weight; word width = 9*KERNEL_WIDTH.
- ADDR_WIDTH, 8, BRAM address width (max 256 kernels).

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load (honoured only in IDLE)
- cfg_last_addr  in  ADDR_WIDTH  number of kernels minus 1; latched on start
- s_tdata  in  KERNEL_WIDTH  weight stream data
- s_tvalid  in  1  stream valid
- s_tlast  in  1  marks final weight of final kernel
- s_tready  out  1  stream ready
- ena_kernel_BRAM  out  1  port A enable
- wea_kernel_BRAM  out  1  port A write enable
- kernel_BRAM_addra  out  ADDR_WIDTH  port A address
- kernel_BRAM_dina  out  9*KERNEL_WIDTH  port A write data
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle completion pulse
- err  out  1  sticky framing error; cleared by next accepted start

Behaviour:
- Reset values: s_tready=0, ena=wea=0, addra=0, dina=0, busy=0, done=0, err=0. State=IDLE. Weight counter=0, address counter=0.
- Reset mid-load returns to IDLE immediately. Words already written remain in the BRAM. The partial word is discarded.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE: on start=1, latch cfg_last_addr, set addr=0, wcnt=0, err=0, busy=1, then go to LOAD. start is ignored in every other state.
- LOAD: s_tready=1. A beat is accepted when s_tvalid&&s_tready. Weight number wcnt (0..8, row-major k00,k01,...,k22) is stored in bits [16*wcnt+15 : 16*wcnt] of the pack register (KERNEL_WIDTH generalises 16). wcnt increments on each beat.
- On the 9th beat (wcnt==8) the FSM goes to WRITE and wcnt returns to 0.
- WRITE lasts exactly one cycle:
  - ena=wea=1, addra=addr, dina=pack register; s_tready=0.
  - If addr==latched last, go to DONE; otherwise increment addr and return to LOAD.
  - Throughput is 10 cycles per kernel with continuous valid.
- ena and wea are high only in WRITE. addra and dina hold their last values otherwise.
- tlast rules:
  - s_tlast=1 on any beat other than the 9th beat of the last kernel is an early tlast. Set err=1, discard the partial word, go to DONE with no further writes.
  - If the 9th beat of the last kernel arrives with s_tlast=0, set err=1. The word is still written and the load completes normally.
- DONE lasts one cycle: done=1, busy drops to 0 on the next cycle, then IDLE. err holds until the next accepted start.
- s_tvalid low in LOAD stalls the load indefinitely without losing state. There is no timeout.
- cfg_last_addr=255 writes all 256 addresses. Address 255 is final, so there is no wrap-around.

Test Plan:
- Reset, then start with cfg_last_addr=0. Stream 0x0001..0x0009 continuously, tlast on the 9th beat. Required: one WRITE cycle, addra=0, dina=0x0009_0008_0007_0006_0005_0004_0003_0002_0001, done pulses, err=0.
- cfg_last_addr=3, 36 beats with value 16*addr+k and tlast on the last beat. Required: 4 writes at addra 0,1,2,3, each 10 cycles apart; s_tready=0 in each WRITE cycle; done once.
- Same as the single-kernel case, with s_tvalid low for 5 cycles after beat 4. Required: identical dina; the write occurs 5 cycles later.
- cfg_last_addr=1, tlast on beat 5 of kernel 0. Required: no write at all, done pulses, err=1. A following start clears err.
- cfg_last_addr=0, no tlast on beat 9. Required: write at addr 0 still occurs, err=1.
- Assert rst mid-kernel-2 of a 4-kernel load. Required: outputs go to reset values asynchronously, no further writes; a new start loads from addr 0.

Source files
------------

// File: rtl/kernel_bram_loader_if.sv
// Control, weight-stream and BRAM port A signals of the kernel BRAM loader.
// The loader uses the slave view; the stream source/controller side uses master.
interface kernel_bram_loader_if #(
    parameter int KERNEL_WIDTH = 16,
    parameter int ADDR_WIDTH   = 8
);
    logic                      start;
    logic [ADDR_WIDTH-1:0]     cfg_last_addr;
    logic [KERNEL_WIDTH-1:0]   s_tdata;
    logic                      s_tvalid;
    logic                      s_tlast;
    logic                      s_tready;
    logic                      ena_kernel_BRAM;
    logic                      wea_kernel_BRAM;
    logic [ADDR_WIDTH-1:0]     kernel_BRAM_addra;
    logic [9*KERNEL_WIDTH-1:0] kernel_BRAM_dina;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (
        output start, cfg_last_addr, s_tdata, s_tvalid, s_tlast,
        input  s_tready, ena_kernel_BRAM, wea_kernel_BRAM, kernel_BRAM_addra,
               kernel_BRAM_dina, busy, done, err
    );

    modport slave (
        input  start, cfg_last_addr, s_tdata, s_tvalid, s_tlast,
        output s_tready, ena_kernel_BRAM, wea_kernel_BRAM, kernel_BRAM_addra,
               kernel_BRAM_dina, busy, done, err
    );
endinterface

// File: rtl/kernel_bram_loader.sv
// Packs nine 3x3 kernel weights per input channel into one word and writes it to BRAM port A.
// 10 cycles per kernel with continuous valid; s_tready is low during the write and outside a load.
module kernel_bram_loader #(
    parameter int KERNEL_WIDTH = 16,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    kernel_bram_loader_if.slave bus
);
    localparam int WORD_WIDTH = 9 * KERNEL_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   last_q, last_d;
    logic [WORD_WIDTH-1:0]   pack_q, pack_d;
    logic                    s_tready_q, s_tready_d;
    logic                    ena_q, ena_d;
    logic                    wea_q, wea_d;
    logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
    logic [WORD_WIDTH-1:0]   dina_q, dina_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic beat;
    logic final_beat;
    logic last_kernel;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        last_d     = last_q;
        pack_d     = pack_q;
        addra_d    = addra_q;
        dina_d     = dina_q;
        err_d      = err_q;
        beat        = bus.s_tvalid && s_tready_q && (state_q == LOAD);
        final_beat  = (wcnt_q == 4'd8);
        last_kernel = (addr_q == last_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    last_d  = bus.cfg_last_addr;
                    addr_d  = '0;
                    wcnt_d  = '0;
                    pack_d  = '0;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    pack_d[wcnt_q*KERNEL_WIDTH +: KERNEL_WIDTH] = bus.s_tdata;
                    // tlast anywhere but the final weight of the final kernel aborts the load
                    if (bus.s_tlast && !(final_beat && last_kernel)) begin
                        err_d   = 1'b1;
                        wcnt_d  = '0;
                        state_d = DONE;
                    end else if (final_beat) begin
                        wcnt_d  = '0;
                        state_d = WRITE;
                        if (last_kernel && !bus.s_tlast) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            WRITE: begin
                if (last_kernel) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        s_tready_d = (state_d == LOAD);
        ena_d      = (state_d == WRITE);
        wea_d      = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        if (state_d == WRITE) begin
            addra_d = addr_q;
            dina_d  = pack_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            addr_q     <= '0;
            last_q     <= '0;
            pack_q     <= '0;
            s_tready_q <= 1'b0;
            ena_q      <= 1'b0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            pack_q     <= pack_d;
            s_tready_q <= s_tready_d;
            ena_q      <= ena_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.s_tready          = s_tready_q;
    assign bus.ena_kernel_BRAM   = ena_q;
    assign bus.wea_kernel_BRAM   = wea_q;
    assign bus.kernel_BRAM_addra = addra_q;
    assign bus.kernel_BRAM_dina  = dina_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.err               = err_q;
endmodule

// File: tb/tb_kernel_bram_loader.sv
// Bench for kernel_bram_loader: directed and randomized loads checked against a
// beat-list reference model of the expected BRAM writes, their timing and err.
module tb_kernel_bram_loader;
    localparam int KW  = 16;
    localparam int AW  = 8;
    localparam int PER = 10;

    logic clk;
    logic rst;

    kernel_bram_loader_if #(.KERNEL_WIDTH(KW), .ADDR_WIDTH(AW)) bus ();

    kernel_bram_loader #(.KERNEL_WIDTH(KW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Write monitor, sampled on the falling edge
    int              wr_addr[$];
    logic [9*KW-1:0] wr_dat[$];
    longint          wr_t[$];
    int              done_cnt;
    int              tready_viol;
    int              wea_viol;

    always @(negedge clk) begin
        if (bus.ena_kernel_BRAM) begin
            wr_addr.push_back(int'(bus.kernel_BRAM_addra));
            wr_dat.push_back(bus.kernel_BRAM_dina);
            wr_t.push_back(longint'($time));
            if (bus.s_tready) tready_viol++;
            if (!bus.wea_kernel_BRAM) wea_viol++;
        end
        if (bus.done) done_cnt++;
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s_tready"}, 160'(bus.s_tready), 160'(0));
        check({tag, " ena"},      160'(bus.ena_kernel_BRAM), 160'(0));
        check({tag, " wea"},      160'(bus.wea_kernel_BRAM), 160'(0));
        check({tag, " addra"},    160'(bus.kernel_BRAM_addra), 160'(0));
        check({tag, " dina"},     160'(bus.kernel_BRAM_dina), 160'(0));
        check({tag, " busy"},     160'(bus.busy), 160'(0));
        check({tag, " done"},     160'(bus.done), 160'(0));
        check({tag, " err"},      160'(bus.err), 160'(0));
    endtask

    // pattern: 0 random, 1 = i+1, 2 = 16*kernel+lane
    // mode:    0 tlast on final beat, 1 early tlast at epos, 2 tlast missing
    // stop_after >= 0 abandons the load after that beat (used for the reset test)
    task automatic run_load(input string tag, input int last, input int pattern, input int mode,
                            input int epos, input int gap_after, input int gap_len,
                            input int stop_after);
        int              total;
        int              nsend;
        logic [KW-1:0]   d[$];
        bit              tl[$];
        int              exp_addr[$];
        logic [9*KW-1:0] exp_word[$];
        longint          exp_t[$];
        bit              exp_err;
        longint          t0;
        int              w;
        logic [9*KW-1:0] word;

        total = 9 * (last + 1);
        for (int i = 0; i < total; i++) begin
            case (pattern)
                1:       d.push_back(KW'(i + 1));
                2:       d.push_back(KW'(16 * (i / 9) + (i % 9)));
                default: d.push_back(KW'($urandom));
            endcase
            tl.push_back((mode == 0 && i == total - 1) || (mode == 1 && i == epos));
        end
        nsend = (mode == 1) ? epos + 1 : total;

        // Reference: every complete group of nine beats becomes one word at address group index
        exp_err = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            if (tl[i] && i != total - 1) begin
                exp_err = 1'b1;
                break;
            end
            if (i % 9 == 8) begin
                word = '0;
                for (int j = 0; j < 9; j++) word |= (9*KW)'(d[i - 8 + j]) << (KW * j);
                exp_addr.push_back(i / 9);
                exp_word.push_back(word);
                exp_t.push_back(longint'(PER) * (10 * (i / 9 + 1)
                    + ((gap_after >= 0 && gap_after < i) ? gap_len : 0)));
            end
            if (i == total - 1 && !tl[i]) exp_err = 1'b1;
        end

        wr_addr.delete(); wr_dat.delete(); wr_t.delete();
        done_cnt = 0; tready_viol = 0; wea_viol = 0;

        @(negedge clk);
        bus.start = 1'b1;
        bus.cfg_last_addr = AW'(last);
        t0 = longint'($time);
        @(negedge clk);
        bus.start = 1'b0;
        bus.cfg_last_addr = AW'($urandom);
        check({tag, " busy after start"}, 160'(bus.busy), 160'(1));
        check({tag, " err cleared by start"}, 160'(bus.err), 160'(0));

        for (int i = 0; i < nsend; i++) begin
            w = 0;
            while (!bus.s_tready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) begin
                check({tag, " s_tready timeout"}, 160'(0), 160'(1));
                break;
            end
            bus.s_tdata  = d[i];
            bus.s_tlast  = tl[i];
            bus.s_tvalid = 1'b1;
            @(negedge clk);
            if (i == stop_after) begin
                bus.s_tvalid = 1'b0;
                bus.s_tlast  = 1'b0;
                return;
            end
            if (i == gap_after) begin
                bus.s_tvalid = 1'b0;
                bus.s_tlast  = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;

        w = 0;
        while (done_cnt == 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check({tag, " done seen"}, 160'(done_cnt > 0), 160'(1));
        @(negedge clk);
        check({tag, " done pulse count"}, 160'(done_cnt), 160'(1));
        check({tag, " busy dropped"}, 160'(bus.busy), 160'(0));
        check({tag, " err"}, 160'(bus.err), 160'(exp_err));
        check({tag, " write count"}, 160'(wr_addr.size()), 160'(exp_addr.size()));
        check({tag, " tready low in write"}, 160'(tready_viol), 160'(0));
        check({tag, " wea with ena"}, 160'(wea_viol), 160'(0));
        for (int k = 0; k < exp_addr.size() && k < wr_addr.size(); k++) begin
            check($sformatf("%s addra[%0d]", tag, k), 160'(wr_addr[k]), 160'(exp_addr[k]));
            check($sformatf("%s dina[%0d]", tag, k), 160'(wr_dat[k]), 160'(exp_word[k]));
            check($sformatf("%s wtime[%0d]", tag, k), 160'(wr_t[k] - t0), 160'(exp_t[k]));
        end
    endtask

    initial begin
        int last, mode, epos, gap_after, nw;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.cfg_last_addr = '0;
        bus.s_tdata = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast = 1'b0;
        done_cnt = 0; tready_viol = 0; wea_viol = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle s_tready", 160'(bus.s_tready), 160'(0));

        // Single kernel, explicit expected word
        run_load("one", 0, 1, 0, 0, -1, 0, -1);
        check("one dina literal", 160'(bus.kernel_BRAM_dina),
              160'(144'h0009_0008_0007_0006_0005_0004_0003_0002_0001));
        check("one addra hold", 160'(bus.kernel_BRAM_addra), 160'(0));

        run_load("four", 3, 2, 0, 0, -1, 0, -1);
        run_load("stall", 0, 1, 0, 0, 3, 5, -1);
        run_load("early", 1, 0, 1, 4, -1, 0, -1);
        run_load("after_err", 0, 0, 0, 0, -1, 0, -1);
        run_load("notlast", 0, 0, 2, 0, -1, 0, -1);

        // Reset during the second kernel of a four-kernel load
        run_load("rst_mid", 3, 0, 0, 0, -1, 0, 12);
        nw = wr_addr.size();
        rst = 1'b1;
        #1;
        check_reset_outputs("async rst");
        repeat (4) @(negedge clk);
        check("rst no extra writes", 160'(wr_addr.size()), 160'(nw));
        check("rst writes before", 160'(nw), 160'(1));
        rst = 1'b0;
        @(negedge clk);
        run_load("after_rst", 0, 0, 0, 0, -1, 0, -1);

        for (int r = 0; r < 8; r++) begin
            last = $urandom_range(0, 4);
            mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            epos = $urandom_range(0, 9 * (last + 1) - 2);
            gap_after = $urandom_range(0, 9 * (last + 1) - 1);
            if (gap_after % 9 == 8) gap_after = -1;
            run_load($sformatf("rand%0d", r), last, 0, mode, epos, gap_after,
                     $urandom_range(1, 4), -1);
        end

        // Full address range: address 255 is the final write
        run_load("full", 255, 0, 0, 0, 1000, 2, -1);
        check("full last addra", 160'(bus.kernel_BRAM_addra), 160'(255));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
